// File: rtl/lsu_request_arbiter_if.sv
// Request/response bundle between the CPU issue path, the RCA ports, the LSQ and the LSU writeback.
// The slave modport is the arbiter's view of the bundle; the master modport is the surrounding system's view.
interface lsu_request_arbiter_if #(
    parameter int unsigned NUM_RCA = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    logic                        cpu_valid;
    logic                        cpu_ready;
    logic [ADDR_W-1:0]           cpu_addr;
    logic [DATA_W-1:0]           cpu_data;
    logic [2:0]                  cpu_fn3;
    logic                        cpu_load;
    logic                        cpu_store;

    logic [NUM_RCA-1:0]          rca_lock;
    logic [NUM_RCA-1:0]          rca_valid;
    logic [NUM_RCA-1:0]          rca_ready;
    logic [NUM_RCA*ADDR_W-1:0]   rca_addr;
    logic [NUM_RCA*DATA_W-1:0]   rca_data;
    logic [NUM_RCA*3-1:0]        rca_fn3;
    logic [NUM_RCA-1:0]          rca_load;
    logic [NUM_RCA-1:0]          rca_store;
    logic [NUM_RCA-1:0]          rca_grant;

    logic                        lsq_valid;
    logic                        lsq_ready;
    logic [ADDR_W-1:0]           lsq_addr;
    logic [DATA_W-1:0]           lsq_data;
    logic [2:0]                  lsq_fn3;
    logic                        lsq_load;
    logic                        lsq_store;
    logic                        lsq_empty;

    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        cpu_rsp_valid;
    logic [NUM_RCA-1:0]          rca_rsp_valid;
    logic [DATA_W-1:0]           rsp_data_out;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data, cpu_fn3, cpu_load, cpu_store,
        input  rca_lock, rca_valid, rca_addr, rca_data, rca_fn3, rca_load, rca_store,
        input  lsq_ready, lsq_empty, rsp_valid, rsp_data,
        output cpu_ready, rca_ready, rca_grant,
        output lsq_valid, lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store,
        output cpu_rsp_valid, rca_rsp_valid, rsp_data_out
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_data, cpu_fn3, cpu_load, cpu_store,
        output rca_lock, rca_valid, rca_addr, rca_data, rca_fn3, rca_load, rca_store,
        output lsq_ready, lsq_empty, rsp_valid, rsp_data,
        input  cpu_ready, rca_ready, rca_grant,
        input  lsq_valid, lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store,
        input  cpu_rsp_valid, rca_rsp_valid, rsp_data_out
    );
endinterface

// File: rtl/lsu_request_arbiter.sv
// CPU / N-channel RCA arbiter in front of the LSQ: round-robin lock ownership, drain barriers,
// outstanding-load limit and tag-based response routing. Optional: LSU_ARB_CPU_FAIRNESS_EN.
module lsu_request_arbiter #(
    parameter int unsigned NUM_RCA         = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_request_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (NUM_RCA > 1) ? $clog2(NUM_RCA) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
`ifdef LSU_ARB_CPU_FAIRNESS_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {NORMAL, DRAIN, SERVICE} state_t;

    typedef struct packed {
        logic             is_rca;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_RCA-1:0] rca_grant_q;
    logic [CNT_W-1:0]   outstanding;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    tag_t               tag_mem [MAX_OUTSTANDING];
    logic               fair_hold;
    logic               after_service;

    logic               any_lock;
    logic               room;
    logic               cpu_open;
    logic               drained;
    logic               push;
    logic               pop;
    tag_t               head_tag;
    tag_t               push_tag;

    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_data;
    logic [2:0]         req_fn3;
    logic               req_load;
    logic               req_store;
    logic               cpu_ready_c;
    logic [NUM_RCA-1:0] rca_ready_c;
    logic [NUM_RCA-1:0] rca_rsp_c;
    logic [IDX_W-1:0]   rr_win;
    logic [IDX_W-1:0]   cand;
    logic               rr_hit;

    assign any_lock = |bus.rca_lock;
    assign room     = outstanding < CNT_W'(MAX_OUTSTANDING);
    assign cpu_open = (state == NORMAL) && (!any_lock || fair_hold);
    assign drained  = bus.lsq_empty && (outstanding == '0);
    assign head_tag = tag_mem[rd_ptr];
    assign pop      = bus.rsp_valid && (outstanding != '0);
    assign push     = req_valid && bus.lsq_ready && req_load;
    assign push_tag = '{is_rca: (state == SERVICE), idx: grant_idx};

    // Owner request mux; nothing issues while draining
    always_comb begin
        req_valid   = 1'b0;
        req_addr    = bus.cpu_addr;
        req_data    = bus.cpu_data;
        req_fn3     = bus.cpu_fn3;
        req_load    = bus.cpu_load;
        req_store   = bus.cpu_store;
        cpu_ready_c = 1'b0;
        rca_ready_c = '0;
        if (cpu_open) begin
            req_valid   = bus.cpu_valid && room;
            cpu_ready_c = bus.lsq_ready && room;
        end else if (state == SERVICE) begin
            req_valid   = bus.rca_valid[grant_idx] && room;
            req_addr    = bus.rca_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            req_data    = bus.rca_data[int'(grant_idx)*DATA_W +: DATA_W];
            req_fn3     = bus.rca_fn3[int'(grant_idx)*3 +: 3];
            req_load    = bus.rca_load[grant_idx];
            req_store   = bus.rca_store[grant_idx];
            rca_ready_c[grant_idx] = bus.lsq_ready && room;
        end
    end

    // First locking channel above the previous winner, wrapping
    always_comb begin
        rr_win = last_grant;
        rr_hit = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_RCA; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_RCA);
            if (!rr_hit && bus.rca_lock[cand]) begin
                rr_win = cand;
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rca_rsp_c = '0;
        if (pop && head_tag.is_rca) rca_rsp_c[head_tag.idx] = 1'b1;
    end

    assign bus.lsq_valid     = req_valid;
    assign bus.lsq_addr      = req_addr;
    assign bus.lsq_data      = req_data;
    assign bus.lsq_fn3       = req_fn3;
    assign bus.lsq_load      = req_load;
    assign bus.lsq_store     = req_store;
    assign bus.cpu_ready     = cpu_ready_c;
    assign bus.rca_ready     = rca_ready_c;
    assign bus.rca_grant     = rca_grant_q;
    assign bus.cpu_rsp_valid = pop && !head_tag.is_rca;
    assign bus.rca_rsp_valid = rca_rsp_c;
    assign bus.rsp_data_out  = bus.rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= NORMAL;
            grant_idx     <= '0;
            last_grant    <= IDX_W'(NUM_RCA - 1);
            rca_grant_q   <= '0;
            outstanding   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fair_hold     <= 1'b0;
            after_service <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      outstanding <= outstanding + CNT_W'(1);
            else if (!push && pop) outstanding <= outstanding - CNT_W'(1);

            case (state)
                NORMAL: begin
                    // A fairness hold ends once the CPU gets one request in or withdraws
                    if (fair_hold) begin
                        if (!bus.cpu_valid || cpu_ready_c) begin
                            fair_hold <= 1'b0;
                            if (any_lock) state <= DRAIN;
                        end
                    end else if (any_lock) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        after_service <= 1'b0;
                        if (FAIR_EN && after_service && bus.cpu_valid) begin
                            state     <= NORMAL;
                            fair_hold <= 1'b1;
                        end else if (any_lock) begin
                            state               <= SERVICE;
                            grant_idx           <= rr_win;
                            last_grant          <= rr_win;
                            rca_grant_q         <= '0;
                            rca_grant_q[rr_win] <= 1'b1;
                        end else begin
                            state <= NORMAL;
                        end
                    end
                end
                SERVICE: begin
                    if (!bus.rca_lock[grant_idx]) begin
                        state         <= DRAIN;
                        rca_grant_q   <= '0;
                        after_service <= 1'b1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

    // Protocol checks: orphan responses and malformed access kinds
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.rsp_valid && (outstanding == '0)));
            if (req_valid) assert (req_load ^ req_store);
        end
    end
endmodule

// File: tb/tb_lsu_request_arbiter.sv
// Randomised bench for lsu_request_arbiter against an ownership/queue reference model.
module tb_lsu_request_arbiter;
    localparam int unsigned NUM_RCA = 2;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAXO    = 4;
    localparam int unsigned IW      = 1;
`ifdef LSU_ARB_CPU_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_request_arbiter_if #(.NUM_RCA(NUM_RCA), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lsu_request_arbiter #(
        .NUM_RCA(NUM_RCA), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner -1 = CPU, -2 = draining, k = channel k
    int owner;
    int last_w;
    bit hold;
    bit after;
    int tagq[$];
    bit lsqq[$];
    int retire_mode;
    bit retire;
    bit e_lv, e_cr, e_load;
    int cpu_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; last_w = NUM_RCA - 1; hold = 1'b0; after = 1'b0;
        tagq.delete(); lsqq.delete();
    endtask

    task automatic set_cpu(input bit v, input logic [31:0] a, input bit ld);
        bus.cpu_valid = v; bus.cpu_addr = a; bus.cpu_data = $urandom;
        bus.cpu_fn3 = 3'($urandom); bus.cpu_load = ld; bus.cpu_store = !ld;
    endtask

    task automatic set_rca(input int k, input bit v, input logic [31:0] a, input bit ld);
        bus.rca_valid[IW'(k)] = v;
        bus.rca_addr[k*ADDR_W +: ADDR_W] = a;
        bus.rca_data[k*DATA_W +: DATA_W] = $urandom;
        bus.rca_fn3[k*3 +: 3] = 3'($urandom);
        bus.rca_load[IW'(k)] = ld;
        bus.rca_store[IW'(k)] = !ld;
    endtask

    task automatic drive_lsq();
        retire = 1'b0;
        if (lsqq.size() > 0)
            retire = (retire_mode == 1) || (retire_mode == 2 && $urandom_range(0, 2) == 0);
        bus.lsq_empty = (lsqq.size() == 0);
        bus.rsp_valid = 1'b0;
        if (retire) bus.rsp_valid = lsqq[0];
        bus.rsp_data = $urandom;
    endtask

    // Compare every DUT output against what ownership and queue contents dictate
    task automatic check_model();
        bit room, cpu_open, pop;
        logic [NUM_RCA-1:0] e_rr, e_grant, e_rrsp;
        bit e_crsp;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic [2:0] ef;
        bit es;
        #1;
        room = tagq.size() < int'(MAXO);
        cpu_open = (owner == -1) && (bus.rca_lock == '0 || hold);
        e_lv = 1'b0; e_cr = 1'b0; e_rr = '0; e_grant = '0;
        ea = bus.cpu_addr; ed = bus.cpu_data; ef = bus.cpu_fn3; e_load = bus.cpu_load; es = bus.cpu_store;
        if (cpu_open) begin
            e_lv = bus.cpu_valid && room;
            e_cr = bus.lsq_ready && room;
        end else if (owner >= 0) begin
            e_lv = bus.rca_valid[IW'(owner)] && room;
            e_rr[IW'(owner)] = bus.lsq_ready && room;
            ea = bus.rca_addr[owner*ADDR_W +: ADDR_W];
            ed = bus.rca_data[owner*DATA_W +: DATA_W];
            ef = bus.rca_fn3[owner*3 +: 3];
            e_load = bus.rca_load[IW'(owner)];
            es = bus.rca_store[IW'(owner)];
        end
        if (owner >= 0) e_grant[IW'(owner)] = 1'b1;
        pop = bus.rsp_valid && tagq.size() > 0;
        e_crsp = 1'b0; e_rrsp = '0;
        if (pop) begin
            if (tagq[0] == -1) e_crsp = 1'b1;
            else e_rrsp[IW'(tagq[0])] = 1'b1;
        end
        if (rst) return;
        chk("lsq_valid", 64'(bus.lsq_valid), 64'(e_lv));
        chk("cpu_ready", 64'(bus.cpu_ready), 64'(e_cr));
        chk("rca_ready", 64'(bus.rca_ready), 64'(e_rr));
        chk("rca_grant", 64'(bus.rca_grant), 64'(e_grant));
        chk("cpu_rsp_valid", 64'(bus.cpu_rsp_valid), 64'(e_crsp));
        chk("rca_rsp_valid", 64'(bus.rca_rsp_valid), 64'(e_rrsp));
        chk("rsp_data_out", 64'(bus.rsp_data_out), 64'(bus.rsp_data));
        if (e_lv) begin
            chk("lsq_addr", 64'(bus.lsq_addr), 64'(ea));
            chk("lsq_data", 64'(bus.lsq_data), 64'(ed));
            chk("lsq_fn3", 64'(bus.lsq_fn3), 64'(ef));
            chk("lsq_load", 64'(bus.lsq_load), 64'(e_load));
            chk("lsq_store", 64'(bus.lsq_store), 64'(es));
        end
    endtask

    // Update the model with this cycle's events, then move to the next falling edge
    task automatic advance();
        bit drained, acc, anylock, pop;
        drained = bus.lsq_empty && tagq.size() == 0;
        anylock = (bus.rca_lock != '0);
        acc = e_lv && bus.lsq_ready;
        pop = bus.rsp_valid && tagq.size() > 0;
        if (rst) begin
            model_reset();
        end else begin
            if (owner == -1) begin
                if (hold) begin
                    if (!bus.cpu_valid || e_cr) begin
                        hold = 1'b0;
                        if (anylock) owner = -2;
                    end
                end else if (anylock) owner = -2;
            end else if (owner == -2) begin
                if (drained) begin
                    if (FAIR && after && bus.cpu_valid) begin
                        owner = -1; hold = 1'b1;
                    end else if (anylock) begin
                        for (int i = 1; i <= int'(NUM_RCA); i++) begin
                            int c;
                            c = (last_w + i) % int'(NUM_RCA);
                            if (owner == -2 && bus.rca_lock[IW'(c)]) owner = c;
                        end
                        last_w = owner;
                    end else owner = -1;
                    after = 1'b0;
                end
            end else if (!bus.rca_lock[IW'(owner)]) begin
                owner = -2; after = 1'b1;
            end
            if (pop) void'(tagq.pop_front());
            if (retire) void'(lsqq.pop_front());
            if (acc) begin
                lsqq.push_back(e_load);
                if (e_load) tagq.push_back((e_cr && bus.cpu_valid) ? -1 : last_w);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        drive_lsq();
        check_model();
        advance();
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < int'(NUM_RCA); k++) begin
            set_rca(k, 1'($urandom), $urandom, 1'($urandom));
            if (bus.rca_lock[IW'(k)]) begin
                if ($urandom_range(0, 9) == 0) bus.rca_lock[IW'(k)] = 1'b0;
            end else if ($urandom_range(0, 24) == 0) bus.rca_lock[IW'(k)] = 1'b1;
        end
        set_cpu(1'($urandom), $urandom, 1'($urandom));
        bus.lsq_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int prev;
        bit first;
        int gaps;
        int svc;
        model_reset();
        set_cpu(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < int'(NUM_RCA); k++) set_rca(k, 1'b0, 32'h0, 1'b1);
        bus.rca_lock = '0; bus.lsq_ready = 1'b1; bus.lsq_empty = 1'b1;
        bus.rsp_valid = 1'b0; bus.rsp_data = '0;
        retire_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_grant", 64'(bus.rca_grant), 64'h0);
        chk("reset_cpu_rsp", 64'(bus.cpu_rsp_valid), 64'h0);
        chk("reset_rca_rsp", 64'(bus.rca_rsp_valid), 64'h0);
        chk("reset_cpu_ready", 64'(bus.cpu_ready), 64'h1);
        rst = 1'b0;

        // CPU load passes straight through, response routes back to the CPU
        set_cpu(1'b1, 32'h100, 1'b1);
        drive_lsq(); check_model();
        chk("d_cpu_lsq_valid", 64'(bus.lsq_valid), 64'h1);
        chk("d_cpu_lsq_addr", 64'(bus.lsq_addr), 64'h100);
        advance();
        set_cpu(1'b0, 32'h0, 1'b1);
        retire_mode = 1;
        drive_lsq(); bus.rsp_data = 32'hCAFE_0001; check_model();
        chk("d_cpu_rsp", 64'(bus.cpu_rsp_valid), 64'h1);
        chk("d_rsp_data", 64'(bus.rsp_data_out), 64'hCAFE_0001);
        advance();

        // Both channels lock: DRAIN, then channel 0 wins first
        retire_mode = 0;
        bus.rca_lock = 2'b11;
        set_cpu(1'b1, 32'h300, 1'b0);
        drive_lsq(); check_model();
        chk("d_lock_cpu_ready", 64'(bus.cpu_ready), 64'h0);
        advance();
        set_rca(0, 1'b1, 32'h200, 1'b0);
        drive_lsq(); check_model();
        chk("d_drain_lsq_valid", 64'(bus.lsq_valid), 64'h0);
        chk("d_drain_grant", 64'(bus.rca_grant), 64'h0);
        advance();
        drive_lsq(); check_model();
        chk("d_grant0", 64'(bus.rca_grant), 64'h1);
        chk("d_ch0_addr", 64'(bus.lsq_addr), 64'h200);
        advance();

        // Channel 0 releases: DRAIN cycle, then channel 1
        bus.rca_lock = 2'b10;
        set_rca(0, 1'b0, 32'h0, 1'b1);
        retire_mode = 1;
        cyc();
        set_rca(0, 1'b1, 32'h204, 1'b1);
        set_rca(1, 1'b1, 32'h400, 1'b1);
        retire_mode = 0;
        drive_lsq(); check_model();
        chk("d_handover_valid", 64'(bus.lsq_valid), 64'h0);
        chk("d_handover_grant", 64'(bus.rca_grant), 64'h0);
        advance();

        // Outstanding limit: four loads accepted, fifth stalls until a response
        for (int i = 0; i < 5; i++) begin
            drive_lsq(); check_model();
            chk("d_grant1", 64'(bus.rca_grant), 64'h2);
            chk("d_limit_ready", 64'(bus.rca_ready), (i < 4) ? 64'h2 : 64'h0);
            advance();
        end
        retire_mode = 1;
        drive_lsq(); check_model();
        chk("d_limit_rsp", 64'(bus.rca_rsp_valid), 64'h2);
        chk("d_limit_still_full", 64'(bus.rca_ready), 64'h0);
        advance();
        retire_mode = 0;
        drive_lsq(); check_model();
        chk("d_limit_fifth", 64'(bus.rca_ready), 64'h2);
        advance();

        // Release everything and wait (bounded) for the CPU to own the LSQ again
        bus.rca_lock = '0;
        for (int k = 0; k < int'(NUM_RCA); k++) set_rca(k, 1'b0, 32'h0, 1'b1);
        set_cpu(1'b0, 32'h0, 1'b1);
        retire_mode = 1;
        for (int i = 0; i < 60 && owner != -1; i++) cyc();
        drive_lsq(); check_model();
        chk("d_back_to_cpu", 64'(bus.cpu_ready), 64'h1);
        advance();

        // Random traffic
        retire_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end

        // Persistent locks: count CPU acceptances between consecutive grants
        bus.rca_lock = '0;
        for (int k = 0; k < int'(NUM_RCA); k++) set_rca(k, 1'b0, 32'h0, 1'b1);
        retire_mode = 1;
        for (int i = 0; i < 100 && !(owner == -1 && tagq.size() == 0 && lsqq.size() == 0); i++) cyc();
        bus.lsq_ready = 1'b1;
        first = 1'b1; gaps = 0; svc = 0; cpu_acc = 0;
        for (int i = 0; i < 400; i++) begin
            set_cpu(1'b1, $urandom, 1'($urandom));
            for (int k = 0; k < int'(NUM_RCA); k++) set_rca(k, 1'($urandom), $urandom, 1'($urandom));
            bus.rca_lock = 2'b11;
            if (owner >= 0) begin
                svc++;
                if (svc >= 3) begin
                    bus.rca_lock[IW'(owner)] = 1'b0;
                    svc = 0;
                end
            end else svc = 0;
            prev = owner;
            drive_lsq(); check_model();
            if (bus.cpu_valid && bus.cpu_ready) cpu_acc++;
            advance();
            if (prev < 0 && owner >= 0) begin
                if (!first) begin
                    chk("cpu_between_grants", 64'(cpu_acc), FAIR ? 64'h1 : 64'h0);
                    gaps++;
                end
                first = 1'b0;
                cpu_acc = 0;
            end
        end
        n_checks++;
        if (gaps < 5) begin
            n_fail++;
            $display("FAIL grant_gaps: actual %0d required at least 5", gaps);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
